fma_normalize_pipe: RTL and testbench
=====================================

Name: fma_normalize_pipe

Overview:
- Two-stage pipelined post-add normaliser for the fused multiply-add datapath; the successor to the combinational 48-bit normalise select.
- Selects one of two candidate mantissas, counts leading zeros, left-shifts to put the MSB at bit WIDTH-1, and adjusts the exponent.
- Handles zero and underflow (denormal clamp) and uses a valid/ready handshake with full backpressure.
- Sits between the FMA adder and the rounding stage.

Parameters:
- WIDTH, 48, mantissa width of both candidates and of the output.
- EXP_W, 10, unsigned biased exponent width.
- LZC_W, $clog2(WIDTH+1), leading-zero count width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sel  in  1  1 selects in_op1, 0 selects in_op2.
- in_op1  in  WIDTH  candidate mantissa A (carry-corrected path).
- in_op2  in  WIDTH  candidate mantissa B (direct path).
- in_exp  in  EXP_W  exponent associated with the selected mantissa.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_mant  out  WIDTH  normalised mantissa.
- out_exp  out  EXP_W  adjusted exponent.
- out_lzc  out  LZC_W  shift amount actually applied.
- out_zero  out  1  selected mantissa was all zeros.
- out_uflow  out  1  full normalisation was clamped by the exponent.

Behaviour:
- Reset (rst=1 at a clock edge): both stage valid bits clear. out_valid=0, out_mant=0, out_exp=0, out_lzc=0, out_zero=0, out_uflow=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight beats. Nothing is emitted for them.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1. This path is combinational from out_ready; there is no skid buffer.
- Stall: when out_ready=0 and both stages are full, in_ready=0 and all stage registers hold. Output fields stay stable while out_valid=1 and out_ready=0.
- Stage 1 (on input transfer):
  - m = in_sel ? in_op1 : in_op2.
  - Register m and in_exp, plus lzc = number of leading zeros of m (0..WIDTH; WIDTH when m==0).
  - s1_valid <= in_valid whenever adv1; otherwise hold.
- Stage 2 (when adv2 and s1_valid):
  - zero case (m==0): out_mant=0, out_exp=0, out_lzc=WIDTH, out_zero=1, out_uflow=0.
  - normal case (lzc <= exp): out_mant = m << lzc, out_exp = exp - lzc, out_lzc = lzc, out_zero=0, out_uflow=0.
  - underflow case (lzc > exp): out_mant = m << exp, out_exp = 0, out_lzc = exp (truncated to LZC_W), out_uflow=1, out_zero=0.
  - Compare lzc and exp at width max(EXP_W, LZC_W), zero-extended.
  - s2_valid <= s1_valid when adv2; otherwise hold.
- Latency: 2 cycles from input transfer to out_valid, with no stalls. Throughput: 1 beat/cycle.
- Simultaneous output transfer and stage-1 advance in the same cycle is legal and must not drop or duplicate a beat.
- Arithmetic:
  - Shifts are logical; bits shifted out of the top are impossible (MSB already at the top in the normal case).
  - Exponent subtraction never wraps, because of the underflow clamp.
- An already-normalised input (MSB=1) passes with lzc=0 and the exponent unchanged.

Test Plan:
- Reset then idle: after rst, out_valid=0, in_ready=1, all outputs 0. Assert rst with 2 beats in flight; neither is emitted.
- Normalise: sel=0, op2=48'h0000_0000_8000, exp=100 -> 2 cycles later out_mant=48'h8000_0000_0000, out_lzc=32, out_exp=68, flags 0.
- Select/pass-through: sel=1, op1=48'h8000_0000_0001, op2=0, exp=5 -> out_mant=48'h8000_0000_0001, out_lzc=0, out_exp=5, out_zero=0 (proves op1 chosen).
- Zero and underflow:
  - op=0, exp=50 -> out_zero=1, out_mant=0, out_exp=0, out_lzc=48.
  - op=48'h0000_0000_0001, exp=3 -> out_uflow=1, out_mant=48'h0000_0000_0008, out_exp=0, out_lzc=3.
- Backpressure: stream 10 beats with exp=i and op=1<<(47-i) for i=0..9, toggling out_ready randomly (including long 0 runs).
  - All 10 outputs appear in order, with no loss or duplicates.
  - Each has mant=48'h8000_0000_0000 and exp=0.
  - Outputs stay stable while stalled; in_ready drops only when both stages are full and out_ready=0.
- Full throughput: out_ready=1, in_valid=1 for 20 cycles -> 20 outputs on 20 consecutive cycles, starting 2 cycles after the first input.

Source files
------------

// File: rtl/fma_normalize_pipe_if.sv
// Handshake bundle for the FMA post-add normaliser.
// Input side: in_valid/in_ready with the two candidate mantissas, a select and
// the exponent. Output side: out_valid/out_ready with the normalised mantissa,
// adjusted exponent, applied shift and zero/underflow flags.
// Modports: slave is the normaliser, master is the upstream/downstream driver.
interface fma_normalize_pipe_if #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned EXP_W = 10,
  localparam int unsigned LZC_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_op1;
  logic [WIDTH-1:0] in_op2;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic [LZC_W-1:0] out_lzc;
  logic             out_zero;
  logic             out_uflow;

  modport slave (
    input  in_valid, in_sel, in_op1, in_op2, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_lzc, out_zero, out_uflow
  );

  modport master (
    output in_valid, in_sel, in_op1, in_op2, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_lzc, out_zero, out_uflow
  );
endinterface

// File: rtl/fma_normalize_pipe.sv
// Two-stage post-add normaliser for the FMA datapath.
// Stage 1 selects a candidate mantissa and counts its leading zeros; stage 2
// shifts the MSB to the top and lowers the exponent, clamping at exponent 0
// (denormal) and flagging all-zero mantissas. Full valid/ready backpressure,
// no skid buffer: in_ready is combinational from out_ready.
// Ports: clk, rst (synchronous, active-high), bus (slave side of the bundle).
module fma_normalize_pipe #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned EXP_W = 10,
  localparam int unsigned LZC_W = $clog2(WIDTH + 1)
) (
  input logic                clk,
  input logic                rst,
  fma_normalize_pipe_if.slave bus
);

  localparam int unsigned CMP_W = (EXP_W > LZC_W) ? EXP_W : LZC_W;

  logic adv1, adv2;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_mant_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [LZC_W-1:0] s1_lzc_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_mant_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [LZC_W-1:0] s2_lzc_q;
  logic             s2_zero_q;
  logic             s2_uflow_q;

  logic [WIDTH-1:0] sel_mant;
  logic [LZC_W-1:0] sel_lzc;

  logic [WIDTH-1:0] s2_mant_d;
  logic [EXP_W-1:0] s2_exp_d;
  logic [LZC_W-1:0] s2_lzc_d;
  logic             s2_zero_d;
  logic             s2_uflow_d;

  assign adv2         = !s2_valid_q || bus.out_ready;
  assign adv1         = !s1_valid_q || adv2;
  assign bus.in_ready = adv1;

  // Select and leading-zero count; the highest set bit is the last one written.
  always_comb begin
    sel_mant = bus.in_sel ? bus.in_op1 : bus.in_op2;
    sel_lzc  = LZC_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sel_mant[i]) begin
        sel_lzc = LZC_W'(WIDTH - 1 - i);
      end
    end
  end

  // Normalise, clamping the shift at the exponent so it never wraps below 0.
  always_comb begin
    s2_mant_d  = s1_mant_q << s1_lzc_q;
    s2_exp_d   = s1_exp_q - EXP_W'(s1_lzc_q);
    s2_lzc_d   = s1_lzc_q;
    s2_zero_d  = 1'b0;
    s2_uflow_d = 1'b0;
    if (s1_mant_q == '0) begin
      s2_mant_d = '0;
      s2_exp_d  = '0;
      s2_lzc_d  = LZC_W'(WIDTH);
      s2_zero_d = 1'b1;
    end else if (CMP_W'(s1_lzc_q) > CMP_W'(s1_exp_q)) begin
      s2_mant_d  = s1_mant_q << s1_exp_q;
      s2_exp_d   = '0;
      s2_lzc_d   = LZC_W'(s1_exp_q);
      s2_uflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_lzc_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_lzc_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_uflow_q <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_mant_q <= sel_mant;
          s1_exp_q  <= bus.in_exp;
          s1_lzc_q  <= sel_lzc;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_mant_q  <= s2_mant_d;
          s2_exp_q   <= s2_exp_d;
          s2_lzc_q   <= s2_lzc_d;
          s2_zero_q  <= s2_zero_d;
          s2_uflow_q <= s2_uflow_d;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_mant  = s2_mant_q;
  assign bus.out_exp   = s2_exp_q;
  assign bus.out_lzc   = s2_lzc_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.out_uflow = s2_uflow_q;

endmodule

// File: tb/tb_fma_normalize_pipe.sv
// Self-checking bench for fma_normalize_pipe: directed literal cases, reset
// behaviour, backpressure stream, full-throughput run and a random phase, all
// scored against a behavioural normalisation model and an in-flight queue.
module tb_fma_normalize_pipe;

  localparam int W = 48;
  localparam int E = 10;

  typedef struct packed {
    logic [47:0] mant;
    logic [9:0]  exp;
    logic [5:0]  lzc;
    logic        zero;
    logic        uflow;
    logic [31:0] cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fma_normalize_pipe_if #(.WIDTH(W), .EXP_W(E)) bus ();

  fma_normalize_pipe #(.WIDTH(W), .EXP_W(E)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Normalise by shifting until the top bit is set, then apply the exponent clamp.
  function automatic beat_t model(input logic sel, input logic [47:0] a, input logic [47:0] b,
                                  input logic [9:0] e);
    beat_t r;
    logic [47:0] m, t;
    int n;
    r = '0;
    m = sel ? a : b;
    if (m == 48'd0) begin
      r.zero = 1'b1;
      r.lzc  = 6'd48;
    end else begin
      t = m;
      n = 0;
      while (!t[47]) begin
        t = t << 1;
        n++;
      end
      if (n > int'(e)) begin
        r.mant  = m << e;
        r.lzc   = 6'(e);
        r.uflow = 1'b1;
      end else begin
        r.mant = t;
        r.exp  = e - 10'(n);
        r.lzc  = 6'(n);
      end
    end
    return r;
  endfunction

  // Scoreboard / protocol monitor, sampling at the falling edge.
  beat_t q[$];
  beat_t prev;
  beat_t ex;
  logic  prev_stall = 1'b0;
  logic  bp_mode = 1'b0;
  int    bp_count = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, !(q.size() == 2 && !bus.out_ready));
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_mant", bus.out_mant, prev.mant);
        check("stall_exp", bus.out_exp, prev.exp);
        check("stall_lzc", bus.out_lzc, prev.lzc);
        check("stall_flags", {bus.out_zero, bus.out_uflow}, {prev.zero, prev.uflow});
      end
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          ex = q.pop_front();
          check("out_mant", bus.out_mant, ex.mant);
          check("out_exp", bus.out_exp, ex.exp);
          check("out_lzc", bus.out_lzc, ex.lzc);
          check("out_zero", bus.out_zero, ex.zero);
          check("out_uflow", bus.out_uflow, ex.uflow);
          check("latency_min", (cyc - int'(ex.cyc)) >= 2, 1);
          if (bp_mode) begin
            check("bp_mant", bus.out_mant, 48'h8000_0000_0000);
            check("bp_exp", bus.out_exp, 0);
            bp_count++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        ex = model(bus.in_sel, bus.in_op1, bus.in_op2, bus.in_exp);
        ex.cyc = 32'(cyc);
        q.push_back(ex);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev.mant  = bus.out_mant;
      prev.exp   = bus.out_exp;
      prev.lzc   = bus.out_lzc;
      prev.zero  = bus.out_zero;
      prev.uflow = bus.out_uflow;
    end
  end

  // One clock: sample at the falling edge, return just after the rising edge.
  logic acc, ov, rdy, oz, ou;
  logic [47:0] om;
  logic [9:0]  oe;
  logic [5:0]  ol;

  task automatic step();
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    rdy = bus.in_ready;
    ov  = bus.out_valid;
    om  = bus.out_mant;
    oe  = bus.out_exp;
    ol  = bus.out_lzc;
    oz  = bus.out_zero;
    ou  = bus.out_uflow;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic sel, input logic [47:0] a,
                          input logic [47:0] b, input logic [9:0] e, input logic [47:0] w_mant,
                          input logic [9:0] w_exp, input logic [5:0] w_lzc, input logic w_zero,
                          input logic w_uflow);
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel    = sel;
    bus.in_op1    = a;
    bus.in_op2    = b;
    bus.in_exp    = e;
    step();
    check({nm, "_accept"}, acc, 1);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (lat == 0) begin
        step();
        if (ov) begin
          lat = k;
          check({nm, "_mant"}, om, w_mant);
          check({nm, "_exp"}, oe, w_exp);
          check({nm, "_lzc"}, ol, w_lzc);
          check({nm, "_zero"}, oz, w_zero);
          check({nm, "_uflow"}, ou, w_uflow);
        end
      end
    end
    check({nm, "_latency"}, lat, 2);
  endtask

  int   run = 0;
  logic rv = 1'b1;

  // Random out_ready with run lengths, biased towards long stalls.
  task automatic rand_ready();
    if (run == 0) begin
      rv  = 1'($urandom_range(0, 1));
      run = rv ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 8));
    end
    run--;
    bus.out_ready = rv;
  endtask

  task automatic drain(input string nm);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      rand_ready();
      step();
      guard++;
    end
    check({nm, "_drained"}, q.size(), 0);
    bus.out_ready = 1'b1;
    step();
    step();
  endtask

  function automatic logic [47:0] rand_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0] >> $urandom_range(0, 50);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int i, guard;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 1'b0;
    bus.in_op1    = '0;
    bus.in_op2    = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;

    // Reset then idle.
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_valid", ov, 0);
    check("rst_ready", rdy, 1);
    check("rst_mant", om, 0);
    check("rst_exp", oe, 0);
    check("rst_lzc", ol, 0);
    check("rst_flags", {oz, ou}, 0);

    // Directed literal cases.
    directed("norm", 1'b0, 48'h0, 48'h0000_0000_8000, 10'd100,
             48'h8000_0000_0000, 10'd68, 6'd32, 1'b0, 1'b0);
    directed("pass", 1'b1, 48'h8000_0000_0001, 48'h0, 10'd5,
             48'h8000_0000_0001, 10'd5, 6'd0, 1'b0, 1'b0);
    directed("zero", 1'b0, 48'hFFFF_FFFF_FFFF, 48'h0, 10'd50,
             48'h0, 10'd0, 6'd48, 1'b1, 1'b0);
    directed("uflow", 1'b0, 48'h0, 48'h0000_0000_0001, 10'd3,
             48'h0000_0000_0008, 10'd0, 6'd3, 1'b0, 1'b1);
    directed("edge", 1'b0, 48'h0, 48'h0000_0000_0001, 10'd47,
             48'h8000_0000_0000, 10'd0, 6'd47, 1'b0, 1'b0);

    // Reset with two beats in flight: nothing may come out afterwards.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op2    = 48'h0000_0001_0000;
    bus.in_exp    = 10'd200;
    step();
    check("mid_acc0", acc, 1);
    bus.in_op2 = 48'h0000_0000_00FF;
    step();
    check("mid_acc1", acc, 1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("mid_no_out", ov, 0);
    end

    // Backpressure stream: each beat normalises exactly to exponent 0.
    bp_mode = 1'b1;
    i = 0;
    guard = 0;
    while (i < 10 && guard < 500) begin
      rand_ready();
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'($urandom_range(0, 1));
      bus.in_op1   = bus.in_sel ? (48'd1 << (47 - i)) : rand_op();
      bus.in_op2   = bus.in_sel ? rand_op() : (48'd1 << (47 - i));
      bus.in_exp   = 10'(i);
      step();
      if (acc) i++;
      guard++;
    end
    bus.in_valid = 1'b0;
    drain("bp");
    bp_mode = 1'b0;
    check("bp_count", bp_count, 10);

    // Full throughput: 20 back-to-back beats, 20 consecutive outputs.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      bus.in_valid = (k < 20);
      bus.in_sel   = 1'($urandom_range(0, 1));
      bus.in_op1   = rand_op();
      bus.in_op2   = rand_op();
      bus.in_exp   = 10'($urandom_range(0, 60));
      step();
      check("tp_accept", acc, k < 20);
      check("tp_valid", ov, (k >= 2 && k < 22));
    end
    bus.in_valid = 1'b0;

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rand_ready();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_sel   = 1'($urandom_range(0, 1));
      bus.in_op1   = rand_op();
      bus.in_op2   = rand_op();
      bus.in_exp   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                 : 10'($urandom_range(0, 50));
      step();
    end
    bus.in_valid = 1'b0;
    drain("rand");

    check("final_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
